// File: rtl/bin_bcd_seq.sv
// bin_bcd_seq: sequential shift-and-add-3 binary to BCD converter.
// One input bit per clock, valid/ready on both sides, overflow flag.
// Optional BIN_BCD_SIGNED_EN: two's complement input plus sign output.
module bin_bcd_seq #(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef BIN_BCD_SIGNED_EN
    ,
    output logic                  sign
`endif
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (IN_WIDTH > 2) ? $clog2(IN_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t              state;
    logic [IN_WIDTH-1:0] sreg;
    logic [BW-1:0]       acc;
    logic [BW-1:0]       adj;
    logic [BW-1:0]       acc_nx;
    logic                ovf_nx;
    logic [CW-1:0]       cnt;
    logic [IN_WIDTH-1:0] load_val;

`ifdef BIN_BCD_SIGNED_EN
    logic sign_q;

    // Load the magnitude; the most negative value maps to 2^(W-1).
    always_comb begin
        load_val = in_data;
        if (in_data[IN_WIDTH-1])
            load_val = ~in_data + IN_WIDTH'(1);
    end
`else
    // Unsigned input is loaded as-is.
    always_comb begin
        load_val = in_data;
    end
`endif

    // Add-3 on every digit >= 5, then shift in the next input bit.
    always_comb begin
        adj = acc;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
        end
        acc_nx = {adj[BW-2:0], sreg[IN_WIDTH-1]};
        ovf_nx = ovf | adj[BW-1];
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            bcd       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            sreg      <= '0;
            acc       <= '0;
`ifdef BIN_BCD_SIGNED_EN
            sign      <= 1'b0;
            sign_q    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg     <= load_val;
                        acc      <= '0;
                        ovf      <= 1'b0;
                        cnt      <= CW'(IN_WIDTH - 1);
                        in_ready <= 1'b0;
                        state    <= CONV;
`ifdef BIN_BCD_SIGNED_EN
                        sign_q   <= in_data[IN_WIDTH-1];
`endif
                    end
                end
                CONV: begin
                    acc  <= acc_nx;
                    sreg <= {sreg[IN_WIDTH-2:0], 1'b0};
                    ovf  <= ovf_nx;
                    if (cnt == '0) begin
                        bcd       <= acc_nx;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef BIN_BCD_SIGNED_EN
                        sign      <= sign_q;
`endif
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_bcd_seq.sv
// tb_bin_bcd_seq: directed vectors plus a per-cycle behavioural model.
// Covers default, 16-bit/5-digit and 8-bit/2-digit instances.
module tb_bin_bcd_seq;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // main instance: 8 bits, 3 digits
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] bcd;
    logic        ovf;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef BIN_BCD_SIGNED_EN
    logic        sign;
`endif

    // wide instance: 16 bits, 5 digits
    logic [15:0] a_in = '0;
    logic        a_iv = 1'b0;
    logic        a_ir;
    logic [19:0] a_bcd;
    logic        a_ovf;
    logic        a_ov;
    logic        a_or = 1'b0;
`ifdef BIN_BCD_SIGNED_EN
    logic        a_sign;
`endif

    // narrow instance: 8 bits, 2 digits
    logic [7:0]  b_in = '0;
    logic        b_iv = 1'b0;
    logic        b_ir;
    logic [7:0]  b_bcd;
    logic        b_ovf;
    logic        b_ov;
    logic        b_or = 1'b0;
`ifdef BIN_BCD_SIGNED_EN
    logic        b_sign;
`endif

    bin_bcd_seq #(.IN_WIDTH(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd       (bcd),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef BIN_BCD_SIGNED_EN
        ,
        .sign      (sign)
`endif
    );

    bin_bcd_seq #(.IN_WIDTH(16), .DIGITS(5)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_in),
        .in_valid  (a_iv),
        .in_ready  (a_ir),
        .bcd       (a_bcd),
        .ovf       (a_ovf),
        .out_valid (a_ov),
        .out_ready (a_or)
`ifdef BIN_BCD_SIGNED_EN
        ,
        .sign      (a_sign)
`endif
    );

    bin_bcd_seq #(.IN_WIDTH(8), .DIGITS(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in),
        .in_valid  (b_iv),
        .in_ready  (b_ir),
        .bcd       (b_bcd),
        .ovf       (b_ovf),
        .out_valid (b_ov),
        .out_ready (b_or)
`ifdef BIN_BCD_SIGNED_EN
        ,
        .sign      (b_sign)
`endif
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    // decimal digits of v, least significant digit first
    function automatic logic [19:0] to_bcd(input int unsigned v,
                                           input int d);
        logic [19:0] r;
        r = '0;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // numeric magnitude of an 8-bit input as the converter sees it
    function automatic int unsigned mag8(input logic [7:0] x);
        int unsigned u;
        u = {24'd0, x};
`ifdef BIN_BCD_SIGNED_EN
        if (x[7])
            u = 256 - u;
`endif
        return u;
    endfunction

    // behavioural model of the main instance, cycle by cycle
    logic        m_started = 1'b0;
    logic        m_ready;
    logic        m_valid;
    logic [11:0] m_bcd;
    logic        m_ovf;
    logic        m_sign;
    logic        m_sgn_in;
    int          m_left;
    int unsigned m_val;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_started = 1'b1;
            m_ready   = 1'b1;
            m_valid   = 1'b0;
            m_bcd     = '0;
            m_ovf     = 1'b0;
            m_sign    = 1'b0;
            m_left    = 0;
        end else if (m_ready && in_valid) begin
            m_ready  = 1'b0;
            m_left   = 8;
            m_val    = mag8(in_data);
            m_sgn_in = in_data[7];
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1'b1;
                m_bcd   = to_bcd(m_val, 3)[11:0];
                m_ovf   = (m_val >= 1000);
                m_sign  = m_sgn_in;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
            m_ready = 1'b1;
        end
    end

    // compare main instance against the model every cycle
    always @(negedge clk) begin
        if (m_started) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("bcd", {20'd0, bcd}, {20'd0, m_bcd});
            if (m_valid) begin
                chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
`ifdef BIN_BCD_SIGNED_EN
                chk("sign", {31'd0, sign}, {31'd0, m_sign});
`endif
            end
        end
    end

    // one conversion on the main instance with literal expectations
    task automatic run_main(input logic [7:0]  v,
                            input logic [11:0] eb,
                            input logic        eo,
                            input logic        es,
                            input int          hold);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("main_in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_data  = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("main_latency", n, 32'd8);
        chk("main_bcd_lit", {20'd0, bcd}, {20'd0, eb});
        chk("main_ovf_lit", {31'd0, ovf}, {31'd0, eo});
`ifdef BIN_BCD_SIGNED_EN
        chk("main_sign_lit", {31'd0, sign}, {31'd0, es});
`else
        if (es) $display("note: sign ignored in unsigned build");
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_bcd", {20'd0, bcd}, {20'd0, eb});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("main_drop_valid", {31'd0, out_valid}, 32'd0);
        chk("main_ready_back", {31'd0, in_ready}, 32'd1);
        chk("main_bcd_kept", {20'd0, bcd}, {20'd0, eb});
    endtask

    task automatic run_a(input logic [15:0] v,
                         input logic [19:0] eb,
                         input logic        es);
        int n;
        n = 0;
        while (!a_ir && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("a_in_ready_wait", {31'd0, a_ir}, 32'd1);
        a_in = v;
        a_iv = 1'b1;
        @(negedge clk);
        a_iv = 1'b0;
        n = 0;
        while (!a_ov && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("a_latency", n, 32'd16);
        chk("a_bcd", {12'd0, a_bcd}, {12'd0, eb});
        chk("a_ovf", {31'd0, a_ovf}, 32'd0);
`ifdef BIN_BCD_SIGNED_EN
        chk("a_sign", {31'd0, a_sign}, {31'd0, es});
`else
        if (es) $display("note: sign ignored in unsigned build");
`endif
        a_or = 1'b1;
        @(negedge clk);
        a_or = 1'b0;
        chk("a_drop_valid", {31'd0, a_ov}, 32'd0);
    endtask

    task automatic run_b(input logic [7:0] v,
                         input logic [7:0] eb,
                         input logic       eo);
        int n;
        n = 0;
        while (!b_ir && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b_in_ready_wait", {31'd0, b_ir}, 32'd1);
        b_in = v;
        b_iv = 1'b1;
        @(negedge clk);
        b_iv = 1'b0;
        n = 0;
        while (!b_ov && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b_latency", n, 32'd8);
        chk("b_bcd", {24'd0, b_bcd}, {24'd0, eb});
        chk("b_ovf", {31'd0, b_ovf}, {31'd0, eo});
        b_or = 1'b1;
        @(negedge clk);
        b_or = 1'b0;
        chk("b_drop_valid", {31'd0, b_ov}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_bcd", {20'd0, bcd}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef BIN_BCD_SIGNED_EN
        run_main(8'h80, 12'h128, 1'b0, 1'b1, 5);
        run_main(8'hFF, 12'h001, 1'b0, 1'b1, 0);
        run_main(8'h7F, 12'h127, 1'b0, 1'b0, 0);
        run_main(8'h00, 12'h000, 1'b0, 1'b0, 0);
        run_main(8'h9C, 12'h100, 1'b0, 1'b1, 0);
`else
        run_main(8'd255, 12'h255, 1'b0, 1'b0, 5);
        run_main(8'd0,   12'h000, 1'b0, 1'b0, 0);
        run_main(8'd9,   12'h009, 1'b0, 1'b0, 0);
        run_main(8'd10,  12'h010, 1'b0, 1'b0, 0);
        run_main(8'd99,  12'h099, 1'b0, 1'b0, 0);
        run_main(8'd100, 12'h100, 1'b0, 1'b0, 0);
        run_main(8'd128, 12'h128, 1'b0, 1'b0, 0);
        run_main(8'd200, 12'h200, 1'b0, 1'b0, 2);
`endif

        // reset during the third conversion cycle discards the value
        in_data  = 8'd77;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_bcd", {20'd0, bcd}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_result", {31'd0, out_valid}, 32'd0);
        end

`ifdef BIN_BCD_SIGNED_EN
        run_a(16'h7FFF, 20'h32767, 1'b0);
        run_a(16'h8000, 20'h32768, 1'b1);
        run_b(8'h85, 8'h23, 1'b1);
        run_b(8'd45, 8'h45, 1'b0);
`else
        run_a(16'd65535, 20'h65535, 1'b0);
        run_a(16'd40960, 20'h40960, 1'b0);
        run_b(8'd123, 8'h23, 1'b1);
        run_b(8'd45,  8'h45, 1'b0);
        run_b(8'd250, 8'h50, 1'b1);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_bcd_seq.md
Name: bin_bcd_seq

Overview:
Parametrised, sequential binary-to-BCD converter using shift-and-add-3 (double dabble), processing one input bit per clock. Generalises the combinational 8-bit/3-digit converter to any input width and digit count, with valid/ready handshakes on both sides and an overflow flag. Sits between the datapath/register file and the 7-segment display drivers, where a multi-cycle latency is acceptable and area matters more than speed.

Parameters:
IN_WIDTH, 8, binary input width in bits (>=2).
DIGITS, 3, number of BCD output digits (>=1); the caller sizes this so that 10^DIGITS > 2^IN_WIDTH-1, otherwise overflow can occur.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous, active-low reset.
in_data  input  IN_WIDTH  unsigned binary value to convert.
in_valid  input  1  in_data is valid.
in_ready  output  1  converter can accept a new value.
bcd  output  4*DIGITS  result; digit k in bits [4k+3:4k], k=0 is the units digit.
ovf  output  1  result did not fit in DIGITS digits.
out_valid  output  1  bcd/ovf are valid.
out_ready  input  1  consumer accepts the result.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at a clk edge): state=IDLE, bcd=0, ovf=0, out_valid=0, in_ready=1, bit counter=0. Applies mid-conversion; the in-flight value is discarded and no result is produced.
- FSM states: IDLE, CONV, DONE.
- IDLE: in_ready=1. When in_valid=1 at an edge, capture in_data into the shift register, clear the BCD accumulator and ovf, set counter=IN_WIDTH-1, and go to CONV.
- CONV: in_ready=0, out_valid=0. Each cycle, first add 3 to every accumulator digit >=5. Then shift {accumulator, shift register} left by one: input MSB first, and the MSB of the top digit shifts out. If the shifted-out bit is 1, set ovf (sticky for this conversion). When counter=0, go to DONE; otherwise decrement the counter.
- CONV lasts exactly IN_WIDTH cycles. The value is accepted at edge N and out_valid=1 from edge N+IN_WIDTH.
- DONE: out_valid=1; bcd and ovf are held stable. When out_ready=1 at an edge, out_valid drops and the FSM returns to IDLE (in_ready=1 on the next cycle). No back-to-back acceptance in the same edge.
- in_valid while not IDLE is ignored; the producer holds it.
- Overflow: bcd holds the value modulo 10^DIGITS, and ovf=1.
- bcd keeps its last result after the handshake until the next conversion completes.
- Arithmetic: the add-3 is a 4-bit add with no carry between digits. For valid digits (<=9 before adjust) no digit exceeds 15 after adjust.
- The counter is $clog2(IN_WIDTH) bits wide, minimum 1.

Optional Feature:
Macro BIN_BCD_SIGNED_EN.
- Defined: in_data is two's complement, and an extra output sign (1 bit, registered with bcd, reset 0) is added. On acceptance, sign=in_data[MSB] and the magnitude (negated if negative) is loaded. The most-negative value -2^(IN_WIDTH-1) converts to magnitude 2^(IN_WIDTH-1) correctly, with an IN_WIDTH-bit unsigned magnitude. Latency is unchanged.
- Undefined: the port sign does not exist and in_data is unsigned.

Test Plan:
- Default params, in_data=8'd255 accepted at edge N -> out_valid at N+8, bcd=12'h255, ovf=0; out_ready=1 -> IDLE, in_ready=1 next cycle.
- in_data=8'd0, then 8'd9, 8'd10, 8'd99, 8'd100 back-to-back via handshakes -> bcd=000, 009, 010, 099, 100, ovf=0 each.
- IN_WIDTH=16, DIGITS=5, in_data=16'd65535 -> bcd=20'h65535 after 16 cycles; in_data=16'd40960 -> 20'h40960.
- IN_WIDTH=8, DIGITS=2, in_data=8'd123 -> bcd=8'h23, ovf=1; next value 8'd45 -> bcd=8'h45, ovf=0 (ovf cleared on acceptance).
- Backpressure and reset: hold out_ready=0 for 5 cycles in DONE -> bcd and out_valid stable. Separately, assert rst_n=0 at CONV cycle 3 -> next cycle IDLE, out_valid=0, bcd=0, no result emitted.
- BIN_BCD_SIGNED_EN, IN_WIDTH=8: in_data=8'h80 -> sign=1, bcd=12'h128; 8'hFF -> sign=1, 12'h001; 8'h7F -> sign=0, 12'h127.
